// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection sequencer: main street rests in green, side street and
// pedestrian WALK are served on request, with all-red clearance between right-of-way changes.
module traffic_phase_scheduler #(
    parameter int TICK_DIV   = 27000000,
    parameter int MAIN_MIN   = 10,
    parameter int SIDE_GREEN = 6,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 1,
    parameter int WALK       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        CLR_A  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        CLR_B  = 3'd5
    } state_t;

    localparam int              PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICK_DIV - 1);
    localparam logic [15:0]     MAIN_MIN_M1  = 16'(MAIN_MIN - 1);
    localparam logic [15:0]     SIDE_G_M1    = 16'(SIDE_GREEN - 1);
    localparam logic [15:0]     YELLOW_M1    = 16'(YELLOW - 1);
    localparam logic [15:0]     ALL_RED_M1   = 16'(ALL_RED - 1);
    localparam logic [15:0]     WALK_TICKS   = 16'(WALK);
    localparam logic [15:0]     TCNT_MAX     = 16'hFFFF;

    // Lamp order: {main_r, main_y, main_g, side_r, side_y, side_g}
    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] l;
        l = 6'b100_100;
        case (s)
            MAIN_G:  l = 6'b001_100;
            MAIN_Y:  l = 6'b010_100;
            SIDE_G:  l = 6'b100_001;
            SIDE_Y:  l = 6'b100_010;
            default: l = 6'b100_100;
        endcase
        return l;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          ped_latch_q, ped_latch_d;
    logic          walk_act_q, walk_act_d;
    logic [5:0]    lamps_q, lamps_d;
    logic          walk_q, walk_d;

    logic side_s1_q, side_s2_q;
    logic ped_s1_q, ped_s2_q, ped_prev_q;

    logic tick;
    logic state_chg;
    logic enter_side;
    logic ped_edge;

    assign tick       = (presc_q == PRESC_MAX);
    assign ped_edge   = ped_s2_q & ~ped_prev_q;
    assign state_chg  = (state_d != state_q);
    assign enter_side = state_chg && (state_d == SIDE_G);

    // Two-flop synchronizers plus the previous ped sample for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side_s1_q  <= 1'b0;
            side_s2_q  <= 1'b0;
            ped_s1_q   <= 1'b0;
            ped_s2_q   <= 1'b0;
            ped_prev_q <= 1'b0;
        end else begin
            side_s1_q  <= side_req;
            side_s2_q  <= side_s1_q;
            ped_s1_q   <= ped_req;
            ped_s2_q   <= ped_s1_q;
            ped_prev_q <= ped_s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_B:   if (tick && tcnt_q == ALL_RED_M1) state_d = MAIN_G;
            MAIN_G:  if (tick && tcnt_q >= MAIN_MIN_M1 && (side_s2_q || ped_latch_q))
                         state_d = MAIN_Y;
            MAIN_Y:  if (tick && tcnt_q == YELLOW_M1)  state_d = CLR_A;
            CLR_A:   if (tick && tcnt_q == ALL_RED_M1) state_d = SIDE_G;
            SIDE_G:  if (tick && tcnt_q == SIDE_G_M1)  state_d = SIDE_Y;
            SIDE_Y:  if (tick && tcnt_q == YELLOW_M1)  state_d = CLR_B;
            default: state_d = CLR_B;
        endcase
    end

    // Every phase restarts its timing from zero so D ticks last exactly D*TICK_DIV cycles
    always_comb begin
        presc_d = presc_q + PW'(1);
        tcnt_d  = tcnt_q;
        if (state_chg) begin
            presc_d = '0;
            tcnt_d  = '0;
        end else if (tick) begin
            presc_d = '0;
            if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + 16'd1;
        end
    end

    // A ped edge coinciding with side-green entry stays latched for the following cycle
    always_comb begin
        ped_latch_d = ped_edge | (ped_latch_q & ~enter_side);
        walk_act_d  = enter_side ? ped_latch_q : walk_act_q;
        lamps_d     = lamp_decode(state_d);
        walk_d      = (state_d == SIDE_G) && walk_act_d && (tcnt_d < WALK_TICKS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLR_B;
            presc_q     <= '0;
            tcnt_q      <= '0;
            ped_latch_q <= 1'b0;
            walk_act_q  <= 1'b0;
            lamps_q     <= 6'b100_100;
            walk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tcnt_q      <= tcnt_d;
            ped_latch_q <= ped_latch_d;
            walk_act_q  <= walk_act_d;
            lamps_q     <= lamps_d;
            walk_q      <= walk_d;
        end
    end

    assign {main_r, main_y, main_g, side_r, side_y, side_g} = lamps_q;
    assign walk  = walk_q;
    assign phase = state_q;

endmodule
